// File: rtl/axis_64to32.sv
// axis_64to32: 64-bit to 32-bit AXI-Stream width down-converter.
// Emits the low word first; TUSER is latched on the first beat of each packet.
module axis_64to32 #(
  parameter int USER_W = 32
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [63:0]       S_AXIS_TDATA,
  input  logic [1:0]        S_AXIS_TKEEP,
  input  logic              S_AXIS_TLAST,
  input  logic [USER_W-1:0] S_AXIS_TUSER,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [31:0]       M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic [USER_W-1:0] M_AXIS_TUSER,
  output logic              PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         data_q, data_d;
  logic                last_q, last_d;
  logic                hi_q, hi_d;
  logic [USER_W-1:0]   user_q, user_d;
  logic                in_pkt_q, in_pkt_d;
  logic                err_q, err_d;
  logic                s_xfr, m_xfr;

  assign s_xfr = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_xfr = M_AXIS_TVALID & M_AXIS_TREADY;

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = data_q[31:0];
    M_AXIS_TLAST  = 1'b0;
    unique case (state_q)
      IDLE: S_AXIS_TREADY = 1'b1;
      LO: begin
        S_AXIS_TREADY = ~hi_q & M_AXIS_TREADY;
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = last_q & ~hi_q;
      end
      HI: begin
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = data_q[63:32];
        M_AXIS_TLAST  = last_q;
      end
      default: ;
    endcase
  end

  assign M_AXIS_TUSER = user_q;
  assign PROTO_ERR    = err_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    last_d   = last_q;
    hi_d     = hi_q;
    user_d   = user_q;
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    if (s_xfr) begin
      data_d   = S_AXIS_TDATA;
      last_d   = S_AXIS_TLAST;
      hi_d     = S_AXIS_TKEEP[1] | ~S_AXIS_TLAST;
      in_pkt_d = ~S_AXIS_TLAST;
      err_d    = err_q | (~S_AXIS_TLAST & ~S_AXIS_TKEEP[1]);
      if (!in_pkt_q) user_d = S_AXIS_TUSER;
    end
    unique case (state_q)
      IDLE: if (s_xfr) state_d = LO;
      LO: begin
        if (m_xfr) begin
          if (hi_q)       state_d = HI;
          else if (s_xfr) state_d = LO;
          else            state_d = IDLE;
        end
      end
      HI: if (m_xfr) state_d = s_xfr ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q  <= IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      hi_q     <= 1'b0;
      user_q   <= '0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      last_q   <= last_d;
      hi_q     <= hi_d;
      user_q   <= user_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

endmodule
